// File: rtl/sign_mag_pkg.sv
// Shared types and constants for the sign-magnitude accumulator slice.
package sign_mag_pkg;

  // Accumulator control states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Negative-zero encoding for an n-bit sign-magnitude word: sign set, magnitude clear.
  function automatic logic [31:0] neg_zero_enc(input int n);
    return 32'd1 << (n - 1);
  endfunction

endpackage

// File: rtl/sign_mag_accum_if.sv
// Handshake bundle for the accumulator: command, operand stream and result stream.
interface sign_mag_accum_if #(
  parameter int N     = 8,
  parameter int LEN_W = 4
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [N-1:0]     in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     result;
  logic             ovf;
  logic             busy;

  // Producer/consumer side that talks to the accumulator.
  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, result, ovf, busy
  );

  // Accumulator side.
  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, result, ovf, busy
  );
endinterface

// File: rtl/sign_mag_sat_add.sv
// Combinational saturating sign-magnitude adder. Operands are ordered by
// magnitude so a single subtractor handles differing signs; -0 is folded to +0
// on the way in and any zero result leaves with a positive sign.
module sign_mag_sat_add
  import sign_mag_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         sat
);

  localparam int M = N - 1;
  localparam logic [N-1:0] NEG_ZERO = N'(neg_zero_enc(N));

  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic [M-1:0] w_big;
  logic [M-1:0] w_small;
  logic         w_big_sgn;
  logic [M:0]   w_add;
  logic [M-1:0] w_mag;
  logic         w_sgn;

  // Normalise, order by magnitude, then add or subtract with saturation.
  always_comb begin
    w_a = (a == NEG_ZERO) ? '0 : a;
    w_b = (b == NEG_ZERO) ? '0 : b;

    if (w_a[M-1:0] >= w_b[M-1:0]) begin
      w_big     = w_a[M-1:0];
      w_big_sgn = w_a[M];
      w_small   = w_b[M-1:0];
    end else begin
      w_big     = w_b[M-1:0];
      w_big_sgn = w_b[M];
      w_small   = w_a[M-1:0];
    end

    w_add = {1'b0, w_big} + {1'b0, w_small};
    sat   = 1'b0;
    w_sgn = w_big_sgn;

    if (w_a[M] == w_b[M]) begin
      if (w_add[M]) begin
        w_mag = '1;
        sat   = 1'b1;
      end else begin
        w_mag = w_add[M-1:0];
      end
    end else begin
      w_mag = w_big - w_small;
    end

    if (w_mag == '0) begin
      w_sgn = 1'b0;
    end

    sum = {w_sgn, w_mag};
  end

endmodule

// File: rtl/sign_mag_accum.sv
// Streaming sign-magnitude accumulator: a start command fixes the burst
// length, operands are summed with saturation one per cycle, and the final
// sum is presented until the consumer takes it.
module sign_mag_accum
  import sign_mag_pkg::*;
#(
  parameter int N     = 8,
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sign_mag_accum_if.slave      bus
);

  state_t           r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [N-1:0]     r_acc;
  logic             r_ovf;
  logic             r_out_valid;

  logic [N-1:0]     w_sum;
  logic             w_sat;

  sign_mag_sat_add #(.N(N)) u_add (
    .a   (r_acc),
    .b   (bus.in_data),
    .sum (w_sum),
    .sat (w_sat)
  );

  // Burst control FSM with accumulator, remaining-count and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt <= bus.len;
            r_acc <= '0;
            r_ovf <= 1'b0;
            if (bus.len == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_ACC: begin
          // in_ready is 1 throughout ACC, so in_valid alone marks a handshake.
          if (bus.in_valid) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_sat;
            r_cnt <= r_cnt - LEN_W'(1);
            if (r_cnt == LEN_W'(1)) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_ACC);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_acc;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_sign_mag_accum.sv
// Directed bench for sign_mag_accum (N=8, LEN_W=4).
module tb_sign_mag_accum;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  sign_mag_accum_if #(.N(8), .LEN_W(4)) bus ();

  sign_mag_accum #(.N(8), .LEN_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start; returns just after the accepting edge.
  task automatic issue_start(input logic [3:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    step();
    bus.start = 1'b0;
  endtask

  // Present one operand for one cycle (caller guarantees in_ready).
  task automatic send(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Consume the result with a one-cycle out_ready pulse.
  task automatic take_result();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    n_tests++;
    if (bus.result !== 8'h00 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: result=%h ovf=%b, required 00 0", bus.result, bus.ovf);
    end
  endtask

  task automatic test_basic();
    issue_start(4'd3);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: in_ready=%b busy=%b, required 1 1", bus.in_ready, bus.busy);
    end
    send(8'h05);
    send(8'h83);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.result !== 8'h02) begin
      n_fail++;
      $display("FAIL basic_partial: out_valid=%b result=%h, required 0 02", bus.out_valid, bus.result);
    end
    send(8'h0A);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'h0C || bus.ovf !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: out_valid=%b result=%h ovf=%b in_ready=%b, required 1 0c 0 0",
               bus.out_valid, bus.result, bus.ovf, bus.in_ready);
    end
    take_result();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: busy=%b out_valid=%b, required 0 0", bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_saturate();
    issue_start(4'd2);
    send(8'h64);
    send(8'h32);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'h7F || bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_result: out_valid=%b result=%h ovf=%b, required 1 7f 1",
               bus.out_valid, bus.result, bus.ovf);
    end
    take_result();
    issue_start(4'd1);
    n_tests++;
    if (bus.ovf !== 1'b0 || bus.result !== 8'h00) begin
      n_fail++;
      $display("FAIL sat_clear: ovf=%b result=%h, required 0 00", bus.ovf, bus.result);
    end
    send(8'h01);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'h01 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_next: out_valid=%b result=%h ovf=%b, required 1 01 0",
               bus.out_valid, bus.result, bus.ovf);
    end
    take_result();
  endtask

  task automatic test_neg_zero();
    issue_start(4'd2);
    send(8'h09);
    send(8'h89);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'h00) begin
      n_fail++;
      $display("FAIL cancel_zero: out_valid=%b result=%h, required 1 00", bus.out_valid, bus.result);
    end
    take_result();
    issue_start(4'd1);
    send(8'h80);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'h00 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_zero_in: out_valid=%b result=%h ovf=%b, required 1 00 0",
               bus.out_valid, bus.result, bus.ovf);
    end
    take_result();
  endtask

  task automatic test_len_zero();
    issue_start(4'd0);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 8'h00) begin
      n_fail++;
      $display("FAIL len_zero: out_valid=%b in_ready=%b result=%h, required 1 0 00",
               bus.out_valid, bus.in_ready, bus.result);
    end
    take_result();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len_zero_idle: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_flow_control();
    issue_start(4'd2);
    send(8'h10);
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 8'h10) begin
        n_fail++;
        $display("FAIL bubble_%0d: in_ready=%b out_valid=%b result=%h, required 1 0 10",
                 i, bus.in_ready, bus.out_valid, bus.result);
      end
    end
    send(8'h85);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        bus.start = 1'b1;
        bus.len   = 4'd5;
      end
      step();
      bus.start = 1'b0;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.result !== 8'h0B || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_%0d: out_valid=%b result=%h busy=%b, required 1 0b 1",
                 i, bus.out_valid, bus.result, bus.busy);
      end
    end
    take_result();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: busy=%b out_valid=%b in_ready=%b, required 0 0 0",
               bus.busy, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    issue_start(4'd3);
    send(8'h20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b busy=%b result=%h, required 0 0 0 00",
               bus.in_ready, bus.out_valid, bus.busy, bus.result);
    end
    issue_start(4'd1);
    send(8'h03);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'h03 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_next: out_valid=%b result=%h ovf=%b, required 1 03 0",
               bus.out_valid, bus.result, bus.ovf);
    end
  endtask

  task automatic test_back_to_back();
    // Prior burst is sitting in DONE; take it and start again on the very next cycle.
    take_result();
    issue_start(4'd1);
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_start: in_ready=%b, required 1", bus.in_ready);
    end
    send(8'h85);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'h85) begin
      n_fail++;
      $display("FAIL b2b_result: out_valid=%b result=%h, required 1 85", bus.out_valid, bus.result);
    end
    take_result();
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturate();
    test_neg_zero();
    test_len_zero();
    test_flow_control();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sign_mag_accum.md
# sign_mag_accum

Streaming sign-and-magnitude accumulator, parametrised in width. A `start` command sets a burst length. The block then accepts that many N-bit sign-magnitude operands over a valid/ready input port and sums them one per cycle with saturation. It returns the final sum over a valid/ready output port. It sits downstream of the combinational sign-magnitude adder datapath and generalises it to multi-operand, flow-controlled, overflow-aware accumulation.

## Interface
- `N`, default 8: word width including sign bit (MSB = sign, N-1 magnitude bits); N ≥ 3.
- `LEN_W`, default 4: width of the burst-length field; maximum burst 2^LEN_W − 1.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a burst; accepted only in IDLE.
- `len`  in  LEN_W  operand count for the burst, sampled with accepted `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  N  sign-magnitude operand.
- `in_ready`  out  1  block accepts an operand this cycle.
- `out_valid`  out  1  `result` and `ovf` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  N  sign-magnitude sum, never negative zero.
- `ovf`  out  1  sticky: at least one accumulation saturated during this burst.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: `in_ready`=0, `out_valid`=0.
    - `start`=1 → load `cnt`=`len`, clear `acc` to +0 and `ovf` to 0, then go to ACC.
    - If `len`=0, go directly to DONE instead.
  - ACC: `in_ready`=1.
    - Each handshake (`in_valid & in_ready`): `acc` ← sat_add(`acc`, `in_data`), `cnt` ← `cnt`−1.
    - Handshake while `cnt`=1 → DONE.
    - `in_valid`=0 cycles are bubbles: no state change.
  - DONE: `out_valid`=1, `result`=`acc`, `in_ready`=0.
    - Hold `result` until `out_ready`=1, then go to IDLE.
- `start` outside IDLE is ignored; `len` is not resampled.
- sat_add arithmetic on magnitudes of N−1 bits:
  - Input −0 (sign=1, mag=0) is treated as +0.
  - Equal signs: sum computed N bits wide. Carry-out → magnitude saturates to all ones, sign kept, `ovf` ← 1.
  - Differing signs: larger magnitude minus smaller; result takes the sign of the larger magnitude.
  - Equal magnitudes with differing signs → +0.
  - Any zero result is forced to sign 0.
- After saturation, accumulation continues from the saturated value. `ovf` stays 1 until the next accepted `start`.

## Timing
- Reset, applied at any time including mid-burst: next cycle state=IDLE, `acc`=0, `cnt`=0, `ovf`=0, `in_ready`=0, `out_valid`=0, `busy`=0, `result`=0.
- `start` accepted in cycle t → `in_ready`=1 in cycle t+1 (or `out_valid`=1 in t+1 when `len`=0).
- Throughput: one operand per cycle in ACC.
- Latency: last operand accepted in cycle t → `out_valid`=1 in cycle t+1.
- Result handshake in cycle t → IDLE in t+1; a new `start` can be accepted in t+1.
- `result`, `ovf` and `out_valid` are registered outputs. `in_ready` and `busy` decode registered state only, with no combinational path from `out_ready` or `in_valid`.

## Structure
- Shared package `sign_mag_pkg`:
  - state enum typedef (IDLE, ACC, DONE);
  - helper constant for the negative-zero encoding.
- One combinational sub-module, `sign_mag_sat_add #(N)`:
  - inputs `a`, `b`; outputs `sum`, `sat`;
  - sorts operands by magnitude, adds or subtracts, saturates, normalises −0.
- Top level holds the FSM, `cnt`, `acc` and the `ovf` registers.

## Test plan
All scenarios use N=8, LEN_W=4.
- `len`=3, operands 0x05, 0x83, 0x0A → `result`=0x0C, `ovf`=0, `out_valid` one cycle after the third handshake.
- `len`=2, operands 0x64, 0x32 → `result`=0x7F, `ovf`=1. A following burst with `len`=1, operand 0x01 → 0x01, `ovf`=0.
- `len`=2, operands 0x09, 0x89 → `result`=0x00. Separately, `len`=1, operand 0x80 → `result`=0x00.
- `len`=0 → `out_valid`=1 one cycle after `start`, `result`=0x00, no input handshakes.
- `len`=2 with `in_valid` bubbles between operands, `out_ready` held low for 3 cycles, and `start` pulsed during DONE:
  - result held stable;
  - `start` ignored;
  - IDLE one cycle after `out_ready` rises.
- `reset` asserted after one of three operands → next cycle `in_ready`=0, `out_valid`=0, `busy`=0. A new burst then sums correctly from +0.
